// File: rtl/io_timer_pkg.sv
// -----------------------------------------------------------------------------
// io_timer_pkg
// Shared definitions for the io_timer block: register word indices, CTRL/STATUS
// bit positions, the IO slot number the system decoder places this block at,
// and the prescaler mask helper.
// -----------------------------------------------------------------------------
package io_timer_pkg;

  // Word register indices (io_addr = addr[4:1])
  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_LOAD   = 4'd2;
  localparam logic [3:0] REG_COUNT  = 4'd3;
  localparam logic [3:0] REG_WDOG   = 4'd4;

  // Register index enumeration, handy for debug views
  typedef enum logic [3:0] {
    IDX_CTRL   = 4'd0,
    IDX_STATUS = 4'd1,
    IDX_LOAD   = 4'd2,
    IDX_COUNT  = 4'd3,
    IDX_WDOG   = 4'd4
  } reg_idx_e;

  // CTRL bit positions
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_AR_BIT = 1;
  localparam int CTRL_IE_BIT = 2;
  localparam int CTRL_PS_LSB = 4;
  localparam int CTRL_PS_W   = 4;

  // STATUS bit positions
  localparam int STATUS_EXP_BIT = 0;

  // IO slot decoded from addr[8:5] by the system top
  localparam logic [3:0] IO_SLOT = 4'd3;

  // Low-bit mask for a 2^ps period: ps=0 -> 0 (every cycle), ps=15 -> 0x7FFF
  function automatic logic [15:0] ps_mask(input logic [3:0] ps);
    return (16'd1 << ps) - 16'd1;
  endfunction

endpackage

// File: rtl/io_timer_prescale.sv
// -----------------------------------------------------------------------------
// timer_prescale
// Free-running 16-bit prescale counter that produces a one-cycle tick every
// 2^ps clock cycles while run is high.
//   clk   : clock
//   reset : synchronous active-high reset
//   run   : advance the counter (hold when low)
//   clear : restart the period from zero (takes priority over run)
//   ps    : prescale exponent, period = 2^ps cycles
//   tick  : high in the last cycle of each period
// -----------------------------------------------------------------------------
module timer_prescale
  import io_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       clear,
  input  logic [3:0] ps,
  output logic       tick
);

  logic [15:0] cnt_r;
  logic [15:0] mask_s;
  logic        match_s;

  // Period mask and end-of-period detect
  always_comb begin
    mask_s  = ps_mask(ps);
    match_s = ((cnt_r & mask_s) == mask_s);
  end

  // Prescale counter: a 2^16 wrap is a multiple of every 2^ps period, so the
  // counter never needs to be reset at the end of a period
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 16'd0;
    end else if (clear) begin
      cnt_r <= 16'd0;
    end else if (run) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A clear restarts the period, so no tick escapes in the clearing cycle
  assign tick = run & ~clear & match_s;

endmodule

// File: rtl/io_timer.sv
// -----------------------------------------------------------------------------
// io_timer
// Memory-mapped down-counting timer with prescaler, auto-reload, sticky expiry
// flag and interrupt, plus an optional watchdog.
// Optional feature macro: TIMER_WDOG_EN (adds register 4, WDOG, and drives
// wdog_reset; without it index 4 is unmapped and wdog_reset is tied low).
//   clk        : clock
//   reset      : synchronous active-high reset
//   io_addr    : word register index
//   io_write   : one-cycle write strobe (already decoded for this slot)
//   io_read    : read strobe, no side effects
//   io_wdata   : write data
//   io_rdata   : combinational read data for io_addr
//   interrupt  : registered EXP & IE
//   wdog_reset : one-cycle watchdog expiry pulse
// Registers: 0 CTRL {PS[7:4], IE[2], AR[1], EN[0]}, 1 STATUS {EXP[0], W1C},
//            2 LOAD, 3 COUNT (live), 4 WDOG (live, optional)
// -----------------------------------------------------------------------------
module io_timer
  import io_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  io_addr,
  input  logic        io_write,
  input  logic        io_read,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  output logic        interrupt,
  output logic        wdog_reset
);

  // Architectural state
  logic        en_r;
  logic        ar_r;
  logic        ie_r;
  logic [3:0]  ps_r;
  logic        exp_r;
  logic [15:0] load_r;
  logic [15:0] count_r;
  logic        int_r;

  // Next-state values
  logic        en_nxt_s;
  logic        ar_nxt_s;
  logic        ie_nxt_s;
  logic [3:0]  ps_nxt_s;
  logic        exp_nxt_s;
  logic [15:0] load_nxt_s;
  logic [15:0] count_nxt_s;

  // Decode and event signals
  logic        wr_ctrl_s;
  logic        wr_status_s;
  logic        wr_load_s;
  logic        wr_count_s;
  logic        tick_s;
  logic        run_s;
  logic        pre_clear_s;
  logic        timer_tick_s;
  logic        expire_s;
  logic [15:0] rdata_s;

  // Reads have no side effects, so the strobe is not needed internally
  logic        unused_s;
  assign unused_s = io_read;

  // Register write decode
  always_comb begin
    wr_ctrl_s   = io_write & (io_addr == REG_CTRL);
    wr_status_s = io_write & (io_addr == REG_STATUS);
    wr_load_s   = io_write & (io_addr == REG_LOAD);
    wr_count_s  = io_write & (io_addr == REG_COUNT);
  end

  // Only an EN 0->1 transition restarts the prescale period
  assign pre_clear_s  = wr_ctrl_s & ~en_r & io_wdata[CTRL_EN_BIT];
  assign timer_tick_s = tick_s & en_r;
  assign expire_s     = timer_tick_s & (count_r == 16'd0);

`ifdef TIMER_WDOG_EN
  logic [15:0] wdog_cnt_r;
  logic        wdog_armed_r;
  logic        wdog_pulse_r;
  logic [15:0] wdog_cnt_nxt_s;
  logic        wdog_armed_nxt_s;
  logic        wdog_pulse_nxt_s;
  logic        wr_wdog_s;
  logic        wdog_tick_s;

  assign wr_wdog_s   = io_write & (io_addr == REG_WDOG);
  assign wdog_tick_s = tick_s & wdog_armed_r;

  // An armed watchdog keeps the prescaler running even with EN low
  assign run_s = en_r | wdog_armed_r;

  // Watchdog next state: a write (kick) beats an expiry in the same cycle
  always_comb begin
    wdog_cnt_nxt_s   = wdog_cnt_r;
    wdog_armed_nxt_s = wdog_armed_r;
    wdog_pulse_nxt_s = 1'b0;
    if (wr_wdog_s) begin
      wdog_cnt_nxt_s   = io_wdata;
      wdog_armed_nxt_s = 1'b1;
    end else if (wdog_tick_s) begin
      if (wdog_cnt_r == 16'd0) begin
        wdog_pulse_nxt_s = 1'b1;
        wdog_armed_nxt_s = 1'b0;
      end else begin
        wdog_cnt_nxt_s = wdog_cnt_r - 16'd1;
      end
    end else begin
      wdog_cnt_nxt_s = wdog_cnt_r;
    end
  end

  // Watchdog state register
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt_r   <= 16'd0;
      wdog_armed_r <= 1'b0;
      wdog_pulse_r <= 1'b0;
    end else begin
      wdog_cnt_r   <= wdog_cnt_nxt_s;
      wdog_armed_r <= wdog_armed_nxt_s;
      wdog_pulse_r <= wdog_pulse_nxt_s;
    end
  end

  assign wdog_reset = wdog_pulse_r;
`else
  assign run_s      = en_r;
  assign wdog_reset = 1'b0;
`endif

  timer_prescale u_prescale (
    .clk   (clk),
    .reset (reset),
    .run   (run_s),
    .clear (pre_clear_s),
    .ps    (ps_r),
    .tick  (tick_s)
  );

  // CTRL next state: a one-shot expiry drops EN unless CTRL is written now
  always_comb begin
    en_nxt_s = en_r;
    ar_nxt_s = ar_r;
    ie_nxt_s = ie_r;
    ps_nxt_s = ps_r;
    if (wr_ctrl_s) begin
      en_nxt_s = io_wdata[CTRL_EN_BIT];
      ar_nxt_s = io_wdata[CTRL_AR_BIT];
      ie_nxt_s = io_wdata[CTRL_IE_BIT];
      ps_nxt_s = io_wdata[CTRL_PS_LSB +: CTRL_PS_W];
    end else if (expire_s && !ar_r) begin
      en_nxt_s = 1'b0;
    end else begin
      en_nxt_s = en_r;
    end
  end

  // EXP next state: a set beats a write-1-to-clear in the same cycle
  always_comb begin
    exp_nxt_s = exp_r;
    if (expire_s) begin
      exp_nxt_s = 1'b1;
    end else if (wr_status_s && io_wdata[STATUS_EXP_BIT]) begin
      exp_nxt_s = 1'b0;
    end else begin
      exp_nxt_s = exp_r;
    end
  end

  // LOAD next state
  always_comb begin
    load_nxt_s = load_r;
    if (wr_load_s) begin
      load_nxt_s = io_wdata;
    end else begin
      load_nxt_s = load_r;
    end
  end

  // COUNT next state: a direct write beats the tick; the counter stops at 0
  always_comb begin
    count_nxt_s = count_r;
    if (wr_count_s) begin
      count_nxt_s = io_wdata;
    end else if (timer_tick_s) begin
      if (count_r != 16'd0) begin
        count_nxt_s = count_r - 16'd1;
      end else if (ar_r) begin
        count_nxt_s = load_r;
      end else begin
        count_nxt_s = count_r;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Timer state and interrupt registers
  always_ff @(posedge clk) begin
    if (reset) begin
      en_r    <= 1'b0;
      ar_r    <= 1'b0;
      ie_r    <= 1'b0;
      ps_r    <= 4'd0;
      exp_r   <= 1'b0;
      load_r  <= 16'd0;
      count_r <= 16'd0;
      int_r   <= 1'b0;
    end else begin
      en_r    <= en_nxt_s;
      ar_r    <= ar_nxt_s;
      ie_r    <= ie_nxt_s;
      ps_r    <= ps_nxt_s;
      exp_r   <= exp_nxt_s;
      load_r  <= load_nxt_s;
      count_r <= count_nxt_s;
      int_r   <= exp_r & ie_r;
    end
  end

  assign interrupt = int_r;

  // Read mux; unmapped indices return 0
  always_comb begin
    rdata_s = 16'd0;
    case (io_addr)
      REG_CTRL: begin
        rdata_s[CTRL_EN_BIT] = en_r;
        rdata_s[CTRL_AR_BIT] = ar_r;
        rdata_s[CTRL_IE_BIT] = ie_r;
        rdata_s[CTRL_PS_LSB +: CTRL_PS_W] = ps_r;
      end
      REG_STATUS: rdata_s[STATUS_EXP_BIT] = exp_r;
      REG_LOAD:   rdata_s = load_r;
      REG_COUNT:  rdata_s = count_r;
`ifdef TIMER_WDOG_EN
      REG_WDOG:   rdata_s = wdog_cnt_r;
`endif
      default:    rdata_s = 16'd0;
    endcase
  end

  assign io_rdata = rdata_s;

endmodule

// File: tb/tb_io_timer.sv
// -----------------------------------------------------------------------------
// tb_io_timer
// Self-checking bench for io_timer. Expected register values are queued when
// the stimulus that causes them is driven and popped when the register is read.
// Inputs change on the falling edge; outputs are sampled just after it.
// -----------------------------------------------------------------------------
module tb_io_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  io_addr;
  logic        io_write;
  logic        io_read;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        interrupt;
  logic        wdog_reset;

  int          total  = 0;
  int          bad    = 0;
  int          pulses = 0;
  logic [15:0] exp_q[$];

  io_timer dut (
    .clk        (clk),
    .reset      (reset),
    .io_addr    (io_addr),
    .io_write   (io_write),
    .io_read    (io_read),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .interrupt  (interrupt),
    .wdog_reset (wdog_reset)
  );

  always #5 clk = ~clk;

  // Count watchdog pulses, one sample per cycle
  always @(negedge clk) begin
    if (wdog_reset === 1'b1) pulses++;
  end

  // Hard time limit
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic sb_push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  // Read a register and compare against the oldest queued expectation
  task automatic sb_read(input string tag, input logic [3:0] a);
    logic [15:0] want;
    io_addr = a;
    io_read = 1'b1;
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s got=%h want=<queue empty>", tag, io_rdata);
    end else begin
      want = exp_q.pop_front();
      check_val(tag, io_rdata, want);
    end
    io_read = 1'b0;
  endtask

  task automatic pin(input string tag, input logic got, input logic want);
    check_val(tag, {15'd0, got}, {15'd0, want});
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Write lands on the rising edge after the next falling edge; returns just
  // after the following falling edge
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    io_addr  = a;
    io_wdata = d;
    io_write = 1'b1;
    @(negedge clk);
    io_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; io_addr = 4'd0; io_write = 1'b0; io_read = 1'b0; io_wdata = 16'd0;
    step(3);
    reset = 1'b0;
    step(1);

    // Reset state
    for (int i = 0; i < 5; i++) sb_push(16'd0);
    sb_read("rst_ctrl", 4'd0);
    sb_read("rst_status", 4'd1);
    sb_read("rst_load", 4'd2);
    sb_read("rst_count", 4'd3);
    sb_read("rst_wdog", 4'd4);
    pin("rst_int", interrupt, 1'b0);
    pin("rst_wdog_pulse", wdog_reset, 1'b0);

    // Auto-reload, PS=0: COUNT 3,2,1,0 then EXP on the 4th tick and reload
    wr(4'd2, 16'd3);
    wr(4'd3, 16'd3);
    wr(4'd0, 16'h0007);
    sb_push(16'd3); sb_push(16'd2); sb_push(16'd1); sb_push(16'd0);
    sb_read("ar_cnt0", 4'd3); step(1);
    sb_read("ar_cnt1", 4'd3); step(1);
    sb_read("ar_cnt2", 4'd3); step(1);
    sb_read("ar_cnt3", 4'd3);
    pin("ar_int_before", interrupt, 1'b0);
    step(1);
    sb_push(16'd3); sb_push(16'd1);
    sb_read("ar_reload", 4'd3);
    sb_read("ar_exp", 4'd1);
    pin("ar_int_same", interrupt, 1'b0);
    step(1);
    pin("ar_int_next", interrupt, 1'b1);
    sb_push(16'd2);
    sb_read("ar_cnt_after", 4'd3);

    // One-shot, PS=2, COUNT=1: ticks every 4 clocks, EXP at the 2nd tick
    wr(4'd0, 16'h0000);
    wr(4'd1, 16'h0001);
    wr(4'd3, 16'd1);
    wr(4'd0, 16'h0025);
    sb_push(16'd1);
    sb_read("os_cnt_start", 4'd3);
    step(3);
    sb_push(16'd1);
    sb_read("os_cnt_pre_tick", 4'd3);
    step(1);
    sb_push(16'd0); sb_push(16'd0);
    sb_read("os_cnt_tick1", 4'd3);
    sb_read("os_exp_tick1", 4'd1);
    step(3);
    sb_push(16'd0);
    sb_read("os_exp_pre_tick2", 4'd1);
    step(1);
    sb_push(16'd1); sb_push(16'h0024); sb_push(16'd0);
    sb_read("os_exp_tick2", 4'd1);
    sb_read("os_en_off", 4'd0);
    sb_read("os_cnt_zero", 4'd3);
    step(10);
    sb_push(16'd0); sb_push(16'h0024);
    sb_read("os_cnt_hold", 4'd3);
    sb_read("os_ctrl_hold", 4'd0);

    // Set beats clear: AR with LOAD=0 sets EXP on every tick
    wr(4'd1, 16'h0001);
    wr(4'd2, 16'd0);
    wr(4'd3, 16'd0);
    sb_push(16'd0);
    sb_read("sc_exp_cleared", 4'd1);
    wr(4'd0, 16'h0007);
    step(2);
    wr(4'd1, 16'h0001);
    sb_push(16'd1); sb_push(16'd0);
    sb_read("sc_set_wins", 4'd1);
    sb_read("sc_cnt_zero", 4'd3);
    pin("sc_int_high", interrupt, 1'b1);
    wr(4'd0, 16'h0004);
    wr(4'd1, 16'h0001);
    sb_push(16'd0);
    sb_read("sc_cleared", 4'd1);
    pin("sc_int_lag", interrupt, 1'b1);
    step(1);
    pin("sc_int_drop", interrupt, 1'b0);

    // COUNT write coincident with a tick wins
    wr(4'd2, 16'h0500);
    wr(4'd3, 16'h0200);
    wr(4'd0, 16'h0003);
    wr(4'd3, 16'h0100);
    sb_push(16'h0100);
    sb_read("cw_write_wins", 4'd3);
    step(1);
    sb_push(16'h00FF);
    sb_read("cw_next_tick", 4'd3);
    wr(4'd0, 16'h0000);

    // Unmapped indices and CTRL reserved bits
    wr(4'd7, 16'hFFFF);
    sb_push(16'h0500); sb_push(16'd0); sb_push(16'd0);
    sb_read("um_load_kept", 4'd2);
    sb_read("um_read7", 4'd7);
    sb_read("um_read15", 4'd15);
    wr(4'd0, 16'hFFFF);
    sb_push(16'h00F7);
    sb_read("ctrl_mask", 4'd0);
    wr(4'd0, 16'h0000);

`ifdef TIMER_WDOG_EN
    // Watchdog: WDOG=2 pulses 3 cycles after the write
    begin
      int p0;
      p0 = pulses;
      wr(4'd4, 16'd2);
      sb_push(16'd2);
      sb_read("wd_cnt2", 4'd4);
      pin("wd_no_pulse0", wdog_reset, 1'b0);
      step(2);
      sb_push(16'd0);
      sb_read("wd_cnt0", 4'd4);
      pin("wd_no_pulse2", wdog_reset, 1'b0);
      step(1);
      pin("wd_pulse", wdog_reset, 1'b1);
      step(1);
      pin("wd_pulse_end", wdog_reset, 1'b0);
      step(4);
      check_val("wd_pulse_once", 16'(pulses - p0), 16'd1);

      // Kick on the cycle before expiry postpones the pulse
      p0 = pulses;
      wr(4'd4, 16'd2);
      step(1);
      sb_push(16'd1);
      sb_read("wk_cnt1", 4'd4);
      wr(4'd4, 16'd2);
      sb_push(16'd2);
      sb_read("wk_reloaded", 4'd4);
      pin("wk_no_pulse", wdog_reset, 1'b0);
      check_val("wk_none_yet", 16'(pulses - p0), 16'd0);
      step(3);
      pin("wk_pulse", wdog_reset, 1'b1);
      step(4);
      check_val("wk_pulse_once", 16'(pulses - p0), 16'd1);
      wr(4'd4, 16'd10);
    end
`else
    wr(4'd4, 16'd2);
    sb_push(16'd0);
    sb_read("wd_unmapped", 4'd4);
    step(6);
    check_val("wd_never", 16'(pulses), 16'd0);
`endif

    // Reset mid-count aborts everything
    wr(4'd1, 16'h0001);
    wr(4'd3, 16'd5);
    wr(4'd0, 16'h0027);
    step(3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    begin
      int p1;
      p1 = pulses;
      for (int i = 0; i < 5; i++) sb_push(16'd0);
      sb_read("mr_ctrl", 4'd0);
      sb_read("mr_status", 4'd1);
      sb_read("mr_load", 4'd2);
      sb_read("mr_count", 4'd3);
      sb_read("mr_wdog", 4'd4);
      pin("mr_int", interrupt, 1'b0);
      step(40);
      sb_push(16'd0); sb_push(16'd0);
      sb_read("mr_no_exp", 4'd1);
      sb_read("mr_count_hold", 4'd3);
      pin("mr_int_after", interrupt, 1'b0);
      check_val("mr_no_pulse", 16'(pulses - p1), 16'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
